interfaz_periferico_spi_top: RTL and testbench



---
 rtl/interfaz_periferico_spi_top.sv | 223 ++++++++++++++++++++++
 tb/tb_interfaz_periferico_spi_top.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/interfaz_periferico_spi_top.sv
// SPI transmit peripheral: switch/button-loaded control register and 8-bit
// data bank, streamed out through an SPI mode-0 master paced by a tick enable.
// The LED address field switches_in[N+7:8] limits N to at most 7.

// Tick generator: one-cycle enable pulse every CLK_IN_FREQ/CLK_OUT_FREQ cycles.
module clock_divider #(
  parameter int CLK_IN_FREQ  = 100_000_000,
  parameter int CLK_OUT_FREQ = 200_000
) (
  input  logic clk_fpga,
  input  logic rst,
  output logic tick_o
);

  localparam int DIV = CLK_IN_FREQ / CLK_OUT_FREQ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  // Free-running counter that wraps on the tick cycle.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick_o) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk_fpga) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

module interfaz_periferico_spi_top #(
  parameter int N            = 7,
  parameter int CLK_IN_FREQ  = 100_000_000,
  parameter int CLK_OUT_FREQ = 200_000
) (
  input  logic        clk_fpga,
  input  logic        rst,
  input  logic        wr_btn,
  input  logic        reg_sel_i,
  input  logic [14:0] switches_in,
  output logic [15:0] salida_o_leds,
  output logic        o_SPI_Clk,
  output logic        o_SPI_MOSI,
  output logic        C_Select
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_STOP
  } state_t;

  logic         tick;
  logic [2:0]   sync_q, sync_d;
  logic         wr_pulse;
  logic         wr_en;
  logic [14:0]  ctrl_q, ctrl_d;
  logic [N-1:0] wr_ptr_q, wr_ptr_d;
  logic         busy_q, busy_d;
  state_t       state_q, state_d;
  logic [N-1:0] word_idx_q, word_idx_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shreg_q, shreg_d;
  logic         sclk_q, sclk_d;
  logic         mosi_q, mosi_d;
  logic         cs_q, cs_d;
  logic [N-1:0] n_end;
  logic [N-1:0] load_addr;
  logic [7:0]   load_word;
  logic [2:0]   ctrl_unused;

  logic [7:0] bank_mem [0:(1<<N)-1];

  clock_divider #(
    .CLK_IN_FREQ (CLK_IN_FREQ),
    .CLK_OUT_FREQ(CLK_OUT_FREQ)
  ) u_div (
    .clk_fpga(clk_fpga),
    .rst     (rst),
    .tick_o  (tick)
  );

  // Bits [14:12] are stored only; they have no effect on the datapath.
  assign ctrl_unused = ctrl_q[14:12];

  // Two sync stages then an edge register; the pulse is high for one cycle per press.
  assign wr_pulse = sync_q[1] & ~sync_q[2];
  assign wr_en    = wr_pulse & ~busy_q;
  assign n_end    = ctrl_q[4 +: N];

  // Word about to be loaded: word 0 when starting, otherwise the next word.
  always_comb begin
    load_addr = word_idx_q + N'(1);
    if (state_q == ST_IDLE) load_addr = '0;
    if (ctrl_q[2])      load_word = 8'hFF;
    else if (ctrl_q[3]) load_word = 8'h00;
    else                load_word = bank_mem[load_addr];
  end

  // Register writes and the tick-paced SPI master state machine.
  always_comb begin
    sync_d     = {sync_q[1:0], wr_btn};
    ctrl_d     = ctrl_q;
    wr_ptr_d   = wr_ptr_q;
    busy_d     = busy_q;
    state_d    = state_q;
    word_idx_d = word_idx_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_d       = cs_q;

    if (wr_en) begin
      if (reg_sel_i) ctrl_d   = switches_in;
      else           wr_ptr_d = wr_ptr_q + N'(1);
    end

    case (state_q)
      ST_IDLE: begin
        cs_d   = ~ctrl_q[1];
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (tick && ctrl_q[0]) begin
          state_d    = ST_START;
          busy_d     = 1'b1;
          word_idx_d = '0;
          bit_cnt_d  = '0;
          shreg_d    = load_word;
          mosi_d     = load_word[7];
          cs_d       = 1'b0;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              if (word_idx_q == n_end) begin
                state_d = ST_STOP;
                mosi_d  = 1'b0;
              end else begin
                word_idx_d = word_idx_q + N'(1);
                shreg_d    = load_word;
                mosi_d     = load_word[7];
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shreg_d   = {shreg_q[6:0], 1'b0};
              mosi_d    = shreg_q[6];
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          ctrl_d[0] = 1'b0;
          cs_d      = ~ctrl_q[1];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      sync_q     <= '0;
      ctrl_q     <= '0;
      wr_ptr_q   <= '0;
      busy_q     <= 1'b0;
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_q       <= 1'b1;
    end else begin
      sync_q     <= sync_d;
      ctrl_q     <= ctrl_d;
      wr_ptr_q   <= wr_ptr_d;
      busy_q     <= busy_d;
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_q       <= cs_d;
    end
  end

  // Data bank write port; contents survive reset.
  always_ff @(posedge clk_fpga) begin
    if (!rst && wr_en && !reg_sel_i) bank_mem[wr_ptr_q] <= switches_in[7:0];
  end

  // LED display: status word or a data word addressed by the upper switches.
  always_comb begin
    salida_o_leds = {8'h00, bank_mem[switches_in[N+7:8]]};
    if (reg_sel_i) salida_o_leds = {busy_q, 3'b000, ctrl_q[11:0]};
  end

  assign o_SPI_Clk  = sclk_q;
  assign o_SPI_MOSI = mosi_q;
  assign C_Select   = cs_q;

endmodule

// File: tb/tb_interfaz_periferico_spi_top.sv
// Scoreboard bench for interfaz_periferico_spi_top: directed writes and bursts,
// with a monitor that reassembles SPI bytes and chip-select windows.
module tb_interfaz_periferico_spi_top;

  localparam int N    = 7;
  localparam int CIN  = 8;
  localparam int COUT = 1;
  localparam int DIV  = CIN / COUT;

  logic        clk_fpga = 1'b0;
  logic        rst = 1'b1;
  logic        wr_btn = 1'b0;
  logic        reg_sel_i = 1'b0;
  logic [14:0] switches_in = '0;
  logic [15:0] salida_o_leds;
  logic        o_SPI_Clk;
  logic        o_SPI_MOSI;
  logic        C_Select;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] byteQ[$];
  int         winCycQ[$];
  int         winPulseQ[$];

  logic       monitorEnable = 1'b0;
  logic       prevSclk = 1'b0;
  logic       prevCs = 1'b1;
  int         monBits = 0;
  logic [7:0] monShift = '0;
  int         monCycles = 0;
  int         monPulses = 0;

  // Free-running system clock.
  always #5 clk_fpga = ~clk_fpga;

  interfaz_periferico_spi_top #(
    .N           (N),
    .CLK_IN_FREQ (CIN),
    .CLK_OUT_FREQ(COUT)
  ) dut (
    .clk_fpga     (clk_fpga),
    .rst          (rst),
    .wr_btn       (wr_btn),
    .reg_sel_i    (reg_sel_i),
    .switches_in  (switches_in),
    .salida_o_leds(salida_o_leds),
    .o_SPI_Clk    (o_SPI_Clk),
    .o_SPI_MOSI   (o_SPI_MOSI),
    .C_Select     (C_Select)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // One button press of holdTicks ticks with the given select and switches.
  task automatic applyStimulus(input logic regSel, input logic [14:0] sw,
                               input int holdTicks);
    @(negedge clk_fpga);
    reg_sel_i   = regSel;
    switches_in = sw;
    wr_btn      = 1'b1;
    repeat (holdTicks * DIV) @(negedge clk_fpga);
    wr_btn = 1'b0;
    repeat (6) @(negedge clk_fpga);
  endtask

  task automatic waitBurstStart();
    int n = 0;
    while (C_Select !== 1'b0 && n < 200) begin
      @(negedge clk_fpga);
      n++;
    end
    checkOutput("burst_start", {31'b0, C_Select}, 32'd0);
  endtask

  task automatic waitBurstEnd();
    int n = 0;
    while (C_Select !== 1'b1 && n < 2000) begin
      @(negedge clk_fpga);
      n++;
    end
    checkOutput("burst_end", {31'b0, C_Select}, 32'd1);
    repeat (3) @(negedge clk_fpga);
  endtask

  task automatic expectWindow(input int words);
    winCycQ.push_back((2 + 16 * words) * DIV);
    winPulseQ.push_back(8 * words);
  endtask

  // Monitor: bytes on SCLK rising edges and chip-select window length/pulses.
  initial begin
    forever begin
      @(negedge clk_fpga);
      if (monitorEnable) begin
        if (prevCs === 1'b1 && C_Select === 1'b0) begin
          monCycles = 0;
          monPulses = 0;
          monBits   = 0;
        end
        if (C_Select === 1'b0) monCycles++;
        if (prevSclk === 1'b0 && o_SPI_Clk === 1'b1) begin
          monPulses++;
          monShift = {monShift[6:0], o_SPI_MOSI};
          monBits++;
          if (monBits == 8) begin
            monBits = 0;
            if (byteQ.size() > 0) checkOutput("spi_byte", {24'b0, monShift}, {24'b0, byteQ.pop_front()});
            else checkOutput("unexpected_byte", {24'b0, monShift}, 32'hFFFF_FFFF);
          end
        end
        if (prevCs === 1'b0 && C_Select === 1'b1) begin
          if (winCycQ.size() > 0) begin
            checkOutput("cs_low_cycles", monCycles, winCycQ.pop_front());
            checkOutput("sclk_pulses", monPulses, winPulseQ.pop_front());
          end else begin
            checkOutput("unexpected_window", monCycles, 32'd0);
          end
        end
      end
      prevSclk = o_SPI_Clk;
      prevCs   = C_Select;
    end
  end

  // Directed sequence.
  initial begin
    repeat (2 * DIV) @(negedge clk_fpga);
    rst = 1'b0;
    reg_sel_i = 1'b1;
    @(negedge clk_fpga);
    checkOutput("reset_cs", {31'b0, C_Select}, 32'd1);
    checkOutput("reset_sclk", {31'b0, o_SPI_Clk}, 32'd0);
    checkOutput("reset_mosi", {31'b0, o_SPI_MOSI}, 32'd0);
    checkOutput("reset_leds", {16'b0, salida_o_leds}, 32'h0000);
    monitorEnable = 1'b1;

    applyStimulus(1'b0, 15'h0033, 1);
    switches_in = 15'h0000;
    @(negedge clk_fpga);
    checkOutput("bank0_readback", {16'b0, salida_o_leds}, 32'h0033);

    applyStimulus(1'b0, 15'h00A5, 2);
    applyStimulus(1'b0, 15'h005A, 1);
    switches_in = 15'h0100;
    @(negedge clk_fpga);
    checkOutput("bank1_held_press", {16'b0, salida_o_leds}, 32'h00A5);
    switches_in = 15'h0200;
    @(negedge clk_fpga);
    checkOutput("bank2_single_write", {16'b0, salida_o_leds}, 32'h005A);

    byteQ.push_back(8'h33);
    expectWindow(1);
    applyStimulus(1'b1, 15'h0001, 1);
    waitBurstStart();
    waitBurstEnd();
    checkOutput("leds_after_one_word", {16'b0, salida_o_leds}, 32'h0000);
    checkOutput("idle_sclk", {31'b0, o_SPI_Clk}, 32'd0);
    checkOutput("idle_mosi", {31'b0, o_SPI_MOSI}, 32'd0);

    byteQ.push_back(8'h33);
    byteQ.push_back(8'hA5);
    expectWindow(2);
    applyStimulus(1'b1, 15'h0011, 1);
    waitBurstStart();
    waitBurstEnd();
    checkOutput("leds_after_two_words", {16'b0, salida_o_leds}, 32'h0010);

    byteQ.push_back(8'hFF);
    expectWindow(1);
    applyStimulus(1'b1, 15'h0005, 1);
    waitBurstStart();
    waitBurstEnd();
    checkOutput("leds_after_all1", {16'b0, salida_o_leds}, 32'h0004);

    byteQ.push_back(8'hFF);
    expectWindow(1);
    applyStimulus(1'b1, 15'h000D, 1);
    waitBurstStart();
    waitBurstEnd();
    checkOutput("leds_after_all1_all0", {16'b0, salida_o_leds}, 32'h000C);

    byteQ.push_back(8'h33);
    expectWindow(1);
    applyStimulus(1'b1, 15'h0001, 1);
    waitBurstStart();
    applyStimulus(1'b0, 15'h0077, 1);
    waitBurstEnd();
    applyStimulus(1'b0, 15'h0066, 1);
    switches_in = 15'h0300;
    @(negedge clk_fpga);
    checkOutput("wr_ptr_unchanged_by_busy_write", {16'b0, salida_o_leds}, 32'h0066);

    monitorEnable = 1'b0;
    applyStimulus(1'b1, 15'h0011, 1);
    waitBurstStart();
    repeat (4 * DIV) @(negedge clk_fpga);
    begin
      int n = 0;
      while (o_SPI_Clk !== 1'b1 && n < 100) begin
        @(negedge clk_fpga);
        n++;
      end
    end
    checkOutput("sclk_high_before_reset", {31'b0, o_SPI_Clk}, 32'd1);
    rst = 1'b1;
    @(posedge clk_fpga);
    #1;
    checkOutput("abort_cs", {31'b0, C_Select}, 32'd1);
    checkOutput("abort_sclk", {31'b0, o_SPI_Clk}, 32'd0);
    checkOutput("abort_mosi", {31'b0, o_SPI_MOSI}, 32'd0);
    @(negedge clk_fpga);
    rst = 1'b0;
    @(negedge clk_fpga);
    checkOutput("abort_leds", {16'b0, salida_o_leds}, 32'h0000);
    repeat (4 * DIV) @(negedge clk_fpga);
    checkOutput("abort_stays_idle", {31'b0, C_Select}, 32'd1);

    checkOutput("pending_bytes", byteQ.size(), 32'd0);
    checkOutput("pending_windows", winCycQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
